// File: rtl/cache_refill.sv
// cache_refill: line-refill engine for the 2-way cache bank.
// On a miss it issues one line-aligned burst read to memory. It then streams
// the returned beats into the victim way, one bank word per cycle, and pulses
// finish so the bank can mark the line valid.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for a miss; the only state that samples i_miss_cache
// S_REQ    | burst request held on the memory port until i_mem_ready
// S_RECV   | writing each returned beat into the bank; stalls on gaps
// S_FINISH | last beat write visible alongside the finish pulse
module cache_refill #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int BANK_NUM   = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_miss_cache,
  input  logic [ADDR_WIDTH-1:0] i_addr_cache,
  input  logic                  i_set_cache,
  output logic                  o_busy_rd,
  output logic [ADDR_WIDTH-1:0] o_addr_rd,
  output logic [DATA_WIDTH-1:0] o_data_rd,
  output logic                  o_wen_rd,
  output logic                  o_set_rd,
  output logic                  o_finish_rd,
  output logic                  o_mem_ren,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  input  logic                  i_mem_ready,
  input  logic                  i_mem_rvalid,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

  localparam int BYTE_NUM   = DATA_WIDTH / 8;
  localparam int LINE_BYTES = BANK_NUM * BYTE_NUM;
  localparam int CNT_W      = $clog2(BANK_NUM);
  localparam int BYTE_SH    = $clog2(BYTE_NUM);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ADDR_WIDTH'(LINE_BYTES - 1);
  localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(BANK_NUM - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_RECV   = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t                  r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic [ADDR_WIDTH-1:0]   r_base;
  logic [ADDR_WIDTH-1:0]   r_addr_rd;
  logic [DATA_WIDTH-1:0]   r_data_rd;
  logic                    r_wen_rd;
  logic                    r_set_rd;
  logic                    r_mem_ren;

  logic [ADDR_WIDTH-1:0]   w_line_base;
  logic [ADDR_WIDTH-1:0]   w_beat_addr;

  // Base is line aligned, so the beat offset never carries past the line.
  assign w_line_base = i_addr_cache & ~LINE_MASK;
  assign w_beat_addr = r_base + (ADDR_WIDTH'(r_cnt) << BYTE_SH);

  // Status flags decode straight from the state register.
  assign o_busy_rd   = (r_state != S_IDLE);
  assign o_finish_rd = (r_state == S_FINISH);
  assign o_addr_rd   = r_addr_rd;
  assign o_data_rd   = r_data_rd;
  assign o_wen_rd    = r_wen_rd;
  assign o_set_rd    = r_set_rd;
  assign o_mem_ren   = r_mem_ren;
  assign o_mem_addr  = r_base;

  // Refill sequencer: request, beat capture and finish handshake.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_base    <= '0;
      r_addr_rd <= '0;
      r_data_rd <= '0;
      r_wen_rd  <= 1'b0;
      r_set_rd  <= 1'b0;
      r_mem_ren <= 1'b0;
    end else begin
      r_wen_rd <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_miss_cache) begin
            r_base    <= w_line_base;
            r_set_rd  <= i_set_cache;
            r_mem_ren <= 1'b1;
            r_state   <= S_REQ;
          end
        end
        S_REQ: begin
          if (i_mem_ready) begin
            r_mem_ren <= 1'b0;
            r_cnt     <= '0;
            r_state   <= S_RECV;
          end
        end
        S_RECV: begin
          if (i_mem_rvalid) begin
            r_data_rd <= i_mem_rdata;
            r_addr_rd <= w_beat_addr;
            r_wen_rd  <= 1'b1;
            r_cnt     <= r_cnt + CNT_W'(1);
            if (r_cnt == LAST_BEAT) begin
              r_state <= S_FINISH;
            end
          end
        end
        S_FINISH: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_refill.sv
// tb_cache_refill: scenario tasks driving cache_refill against a line-level
// reference model (line base = address rounded down to 32 bytes, beat k of a
// line lands at base + 8*k with the k-th returned data word).
module tb_cache_refill;

  logic        clk = 1'b0;
  logic        rstn;
  logic        miss;
  logic [63:0] addr;
  logic        setc;
  logic        ready;
  logic        rvalid;
  logic [63:0] rdata;

  logic        busy_rd;
  logic [63:0] addr_rd;
  logic [63:0] data_rd;
  logic        wen_rd;
  logic        set_rd;
  logic        finish_rd;
  logic        mem_ren;
  logic [63:0] mem_addr;

  int checks = 0;
  int errors = 0;

  // 10 ns clock; inputs change on negedge, outputs sampled on negedge.
  always #5 clk = ~clk;

  cache_refill #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .BANK_NUM(4)) dut (
    .i_clk        (clk),
    .i_rstn       (rstn),
    .i_miss_cache (miss),
    .i_addr_cache (addr),
    .i_set_cache  (setc),
    .o_busy_rd    (busy_rd),
    .o_addr_rd    (addr_rd),
    .o_data_rd    (data_rd),
    .o_wen_rd     (wen_rd),
    .o_set_rd     (set_rd),
    .o_finish_rd  (finish_rd),
    .o_mem_ren    (mem_ren),
    .o_mem_addr   (mem_addr),
    .i_mem_ready  (ready),
    .i_mem_rvalid (rvalid),
    .i_mem_rdata  (rdata)
  );

  // One full refill. mode: 0 back-to-back beats, 1 pattern 1,0,0,1,1,0,1,
  // 2 random gaps. Starts and ends on a negedge; cycles = miss edge to idle.
  task automatic run_refill(input logic [63:0] a, input logic s, input int ready_delay,
                            input int mode, input bit req_noise, input bit miss_noise,
                            output int cycles);
    logic [63:0] base;
    logic [63:0] beats [4];
    logic [6:0]  pat;
    int          n;
    int          idx;
    int          step;
    bit          drv;
    pat  = 7'b1011001;
    base = (a / 64'd32) * 64'd32;
    for (int k = 0; k < 4; k++) beats[k] = {$urandom, $urandom};
    miss = 1'b1; addr = a; setc = s;
    @(posedge clk); @(negedge clk);
    miss = 1'b0; addr = {$urandom, $urandom}; setc = ~s;
    n = 1;
    for (int i = 0; i <= ready_delay; i++) begin
      checks++; if (busy_rd !== 1'b1) begin errors++; $display("FAIL req_busy got=%0h exp=1", busy_rd); end
      checks++; if (mem_ren !== 1'b1) begin errors++; $display("FAIL req_mem_ren got=%0h exp=1", mem_ren); end
      checks++; if (mem_addr !== base) begin errors++; $display("FAIL req_mem_addr got=%0h exp=%0h", mem_addr, base); end
      checks++; if (set_rd !== s) begin errors++; $display("FAIL req_set_rd got=%0h exp=%0h", set_rd, s); end
      checks++; if (wen_rd !== 1'b0) begin errors++; $display("FAIL req_wen got=%0h exp=0", wen_rd); end
      checks++; if (finish_rd !== 1'b0) begin errors++; $display("FAIL req_finish got=%0h exp=0", finish_rd); end
      ready  = (i == ready_delay);
      rvalid = req_noise;
      rdata  = {$urandom, $urandom};
      @(posedge clk); @(negedge clk);
      n++;
    end
    ready = 1'b0; rvalid = 1'b0;
    checks++; if (mem_ren !== 1'b0) begin errors++; $display("FAIL recv_mem_ren got=%0h exp=0", mem_ren); end
    checks++; if (wen_rd !== 1'b0) begin errors++; $display("FAIL recv_entry_wen got=%0h exp=0", wen_rd); end
    idx = 0; step = 0;
    while (idx < 4) begin
      if (step > 60)      drv = 1'b1;
      else if (mode == 0) drv = 1'b1;
      else if (mode == 1) drv = (step < 7) ? pat[step] : 1'b1;
      else                drv = ($urandom_range(0, 2) != 0);
      step++;
      rvalid = drv;
      rdata  = drv ? beats[idx] : {$urandom, $urandom};
      if (miss_noise && step == 2) begin
        miss = 1'b1; addr = 64'h8000; setc = ~s;
      end
      @(posedge clk); @(negedge clk);
      n++;
      miss = 1'b0;
      if (drv) begin
        checks++; if (wen_rd !== 1'b1) begin errors++; $display("FAIL beat_wen got=%0h exp=1 beat=%0d", wen_rd, idx); end
        checks++; if (addr_rd !== base + 64'd8 * idx) begin errors++; $display("FAIL beat_addr got=%0h exp=%0h", addr_rd, base + 64'd8 * idx); end
        checks++; if (data_rd !== beats[idx]) begin errors++; $display("FAIL beat_data got=%0h exp=%0h", data_rd, beats[idx]); end
        idx++;
      end else begin
        checks++; if (wen_rd !== 1'b0) begin errors++; $display("FAIL gap_wen got=%0h exp=0", wen_rd); end
      end
      checks++; if (finish_rd !== (drv && idx == 4)) begin errors++; $display("FAIL recv_finish got=%0h exp=%0h", finish_rd, (drv && idx == 4)); end
      checks++; if (busy_rd !== 1'b1) begin errors++; $display("FAIL recv_busy got=%0h exp=1", busy_rd); end
      checks++; if (mem_ren !== 1'b0) begin errors++; $display("FAIL recv_extra_ren got=%0h exp=0", mem_ren); end
      checks++; if (set_rd !== s) begin errors++; $display("FAIL recv_set_rd got=%0h exp=%0h", set_rd, s); end
      checks++; if (mem_addr !== base) begin errors++; $display("FAIL recv_mem_addr got=%0h exp=%0h", mem_addr, base); end
    end
    // A stray beat during the finish cycle must not be written.
    rvalid = 1'b1; rdata = {$urandom, $urandom};
    @(posedge clk); @(negedge clk);
    n++;
    rvalid = 1'b0;
    checks++; if (busy_rd !== 1'b0) begin errors++; $display("FAIL done_busy got=%0h exp=0", busy_rd); end
    checks++; if (wen_rd !== 1'b0) begin errors++; $display("FAIL done_wen got=%0h exp=0", wen_rd); end
    checks++; if (finish_rd !== 1'b0) begin errors++; $display("FAIL done_finish got=%0h exp=0", finish_rd); end
    checks++; if (mem_ren !== 1'b0) begin errors++; $display("FAIL done_mem_ren got=%0h exp=0", mem_ren); end
    cycles = n;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (busy_rd !== 1'b0) begin errors++; $display("FAIL rst_busy got=%0h exp=0", busy_rd); end
    checks++; if (wen_rd !== 1'b0) begin errors++; $display("FAIL rst_wen got=%0h exp=0", wen_rd); end
    checks++; if (finish_rd !== 1'b0) begin errors++; $display("FAIL rst_finish got=%0h exp=0", finish_rd); end
    checks++; if (mem_ren !== 1'b0) begin errors++; $display("FAIL rst_mem_ren got=%0h exp=0", mem_ren); end
    checks++; if (addr_rd !== 64'd0) begin errors++; $display("FAIL rst_addr_rd got=%0h exp=0", addr_rd); end
    checks++; if (data_rd !== 64'd0) begin errors++; $display("FAIL rst_data_rd got=%0h exp=0", data_rd); end
    checks++; if (set_rd !== 1'b0) begin errors++; $display("FAIL rst_set_rd got=%0h exp=0", set_rd); end
    checks++; if (mem_addr !== 64'd0) begin errors++; $display("FAIL rst_mem_addr got=%0h exp=0", mem_addr); end
    rstn = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++; if (busy_rd !== 1'b0) begin errors++; $display("FAIL rst_idle_busy got=%0h exp=0", busy_rd); end
  endtask

  task automatic test_single();
    int cyc;
    run_refill(64'h1234, 1'b1, 0, 0, 1'b0, 1'b0, cyc);
    checks++; if (cyc !== 7) begin errors++; $display("FAIL single_latency got=%0d exp=7", cyc); end
  endtask

  task automatic test_backpressure();
    int cyc;
    run_refill({$urandom, $urandom}, 1'($urandom_range(0, 1)), 3, 0, 1'b1, 1'b0, cyc);
    checks++; if (cyc !== 10) begin errors++; $display("FAIL bp_latency got=%0d exp=10", cyc); end
  endtask

  task automatic test_gapped();
    int cyc;
    run_refill({$urandom, $urandom}, 1'($urandom_range(0, 1)), 0, 1, 1'b0, 1'b0, cyc);
    checks++; if (cyc !== 10) begin errors++; $display("FAIL gap_latency got=%0d exp=10", cyc); end
  endtask

  task automatic test_busy_filter();
    int cyc;
    run_refill(64'h0000_0000_0001_2345, 1'b0, 1, 0, 1'b0, 1'b1, cyc);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); @(negedge clk);
      checks++; if (mem_ren !== 1'b0) begin errors++; $display("FAIL filt_mem_ren got=%0h exp=0", mem_ren); end
      checks++; if (busy_rd !== 1'b0) begin errors++; $display("FAIL filt_busy got=%0h exp=0", busy_rd); end
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    miss = 1'b1; addr = 64'h0000_00AB_CDEF_0170; setc = 1'b1;
    @(posedge clk); @(negedge clk);
    miss = 1'b0; ready = 1'b1;
    @(posedge clk); @(negedge clk);
    ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rvalid = 1'b1; rdata = {$urandom, $urandom};
      @(posedge clk); @(negedge clk);
    end
    rstn = 1'b0; rvalid = 1'b1; rdata = {$urandom, $urandom};
    @(posedge clk); @(negedge clk);
    checks++; if (busy_rd !== 1'b0) begin errors++; $display("FAIL mid_busy got=%0h exp=0", busy_rd); end
    checks++; if (wen_rd !== 1'b0) begin errors++; $display("FAIL mid_wen got=%0h exp=0", wen_rd); end
    checks++; if (addr_rd !== 64'd0) begin errors++; $display("FAIL mid_addr_rd got=%0h exp=0", addr_rd); end
    checks++; if (data_rd !== 64'd0) begin errors++; $display("FAIL mid_data_rd got=%0h exp=0", data_rd); end
    checks++; if (set_rd !== 1'b0) begin errors++; $display("FAIL mid_set_rd got=%0h exp=0", set_rd); end
    checks++; if (mem_addr !== 64'd0) begin errors++; $display("FAIL mid_mem_addr got=%0h exp=0", mem_addr); end
    checks++; if (mem_ren !== 1'b0) begin errors++; $display("FAIL mid_mem_ren got=%0h exp=0", mem_ren); end
    checks++; if (finish_rd !== 1'b0) begin errors++; $display("FAIL mid_finish got=%0h exp=0", finish_rd); end
    rstn = 1'b1; rvalid = 1'b0;
    run_refill(64'h40, 1'b0, 0, 0, 1'b0, 1'b0, cyc);
    checks++; if (cyc !== 7) begin errors++; $display("FAIL mid_refill_latency got=%0d exp=7", cyc); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    run_refill({$urandom, $urandom}, 1'b0, 0, 0, 1'b0, 1'b0, cyc);
    run_refill({$urandom, $urandom}, 1'b1, 0, 0, 1'b0, 1'b0, cyc);
    checks++; if (cyc !== 7) begin errors++; $display("FAIL b2b_latency got=%0d exp=7", cyc); end
  endtask

  task automatic test_random();
    int          cyc;
    logic [63:0] a;
    for (int r = 0; r < 8; r++) begin
      a = (r == 0) ? 64'hFFFF_FFFF_FFFF_FFF7 : {$urandom, $urandom};
      run_refill(a, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 2,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), cyc);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); @(negedge clk);
      end
    end
  endtask

  initial begin
    rstn = 1'b0; miss = 1'b0; addr = '0; setc = 1'b0;
    ready = 1'b0; rvalid = 1'b0; rdata = '0;
    test_reset();
    test_single();
    test_backpressure();
    test_gapped();
    test_busy_filter();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
